signal_conditioner: RTL

Front-end stage of the frequency counter: takes the raw, asynchronous measured signal and delivers a synchronized, glitch-filtered level (`sig_out`) to the period-measurement stage. It also provides single-cycle edge strobes, a loss-of-signal flag, and a glitch statistics counter. All outputs are registered in the `clk` domain.

---
 rtl/freq_pkg.sv | 14 +
 rtl/sync_chain.sv | 23 ++
 rtl/signal_conditioner.sv | 108 ++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared types and constants for the frequency counter stages
package freq_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } filt_state_t;

    localparam int GLITCH_W   = 16;
    localparam int CLOCK_FREQ = 50000000;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - single-bit multi-flop synchronizer with async reset
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/signal_conditioner.sv
// rtl/signal_conditioner.sv - synchronizer, glitch filter, edge strobes, loss-of-signal and glitch stats
module signal_conditioner
    import freq_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter int          FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear_stats,
    input  logic                raw_in,
    output logic                sig_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                signal_lost,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);
    localparam logic [31:0]    TMAX      = TIMEOUT_CYCLES;

    logic        s;
    filt_state_t state;
    logic [FCW-1:0] fcnt;
    logic [31:0] tcnt;

    logic differ;
    logic pend;
    logic accept;
    logic glitch;
    logic rise_accept;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (s)
    );

    // Comparing against sig_out rather than the state name keeps STABLE/PEND symmetric.
    assign differ      = s ^ sig_out;
    assign pend        = (state == PEND_HIGH) || (state == PEND_LOW);
    assign accept      = enable && differ &&
                         ((!pend && (FILTER_LEN == 1)) || (pend && (fcnt == FCNT_LAST)));
    assign glitch      = enable && pend && !differ;
    assign rise_accept = accept && s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= STABLE_LOW;
            fcnt       <= '0;
            sig_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= accept && s;
            fall_pulse <= accept && !s;
            if (!enable || glitch) begin
                state <= sig_out ? STABLE_HIGH : STABLE_LOW;
                fcnt  <= '0;
            end else if (accept) begin
                sig_out <= s;
                state   <= s ? STABLE_HIGH : STABLE_LOW;
                fcnt    <= '0;
            end else if (differ) begin
                if (!pend) begin
                    state <= s ? PEND_HIGH : PEND_LOW;
                    fcnt  <= FCNT_ONE;
                end else begin
                    fcnt <= fcnt + FCNT_ONE;
                end
            end
        end
    end

    // A rise on the expiry edge clears the counter first, so signal_lost never pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt        <= '0;
            signal_lost <= 1'b0;
        end else if (!enable || rise_accept) begin
            tcnt        <= '0;
            signal_lost <= 1'b0;
        end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 32'd1;
            if (tcnt + 32'd1 == TMAX) begin
                signal_lost <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_count <= '0;
        end else if (clear_stats) begin
            glitch_count <= '0;
        end else if (glitch && (glitch_count != '1)) begin
            glitch_count <= glitch_count + 1'b1;
        end
    end

endmodule
